// File: rtl/cache_mem_pkg.sv
// Shared encodings for the cache/memory burst arbiter: FSM states, owner ids
// and the line-offset width derived from the burst length.
package cache_mem_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    RDATA = 2'd2,
    WDATA = 2'd3
  } arb_state_t;

  typedef enum logic {
    ICACHE = 1'b0,
    DCACHE = 1'b1
  } owner_t;

  localparam int LINE_BURST_LEN = 16;

  // Byte-offset bits inside one line of 32-bit beats.
  function automatic int line_offset_w(input int burst_len);
    return $clog2(burst_len) + 2;
  endfunction

  localparam int LINE_OFFSET_W = line_offset_w(LINE_BURST_LEN);

endpackage

// File: rtl/cache_arb_rr.sv
// Two-input requester picker (I-cache vs D-cache). Round-robin by default;
// CACHE_ARB_DCACHE_PRIORITY_EN selects fixed D-cache priority instead.
module cache_arb_rr
  import cache_mem_pkg::*;
(
  input  logic   clk,
  input  logic   rst,
  input  logic   req_ic,
  input  logic   req_dc,
  input  logic   take,
  output logic   grant_valid,
  output owner_t grant_owner
);

`ifdef CACHE_ARB_DCACHE_PRIORITY_EN

  logic unused_inputs;
  assign unused_inputs = clk ^ rst ^ take;

  always_comb begin
    grant_valid = req_ic | req_dc;
    grant_owner = req_dc ? DCACHE : ICACHE;
  end

`else

  owner_t last_grant;

  // Resets to DCACHE so the I-cache wins the first tie.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      last_grant <= DCACHE;
    end else if (take && grant_valid) begin
      last_grant <= grant_owner;
    end
  end

  always_comb begin
    grant_valid = req_ic | req_dc;
    grant_owner = ICACHE;
    if (req_ic && req_dc) begin
      grant_owner = (last_grant == ICACHE) ? DCACHE : ICACHE;
    end else if (req_dc) begin
      grant_owner = DCACHE;
    end
  end

`endif

endmodule

// File: rtl/cache_mem_arbiter.sv
// Shares the external memory burst port between I-cache refills and D-cache
// refills/writebacks, one line at a time. Optional macro: CACHE_ARB_DCACHE_PRIORITY_EN.
module cache_mem_arbiter
  import cache_mem_pkg::*;
#(
  parameter int DATA_WIDTH    = 32,
  parameter int ADDRESS_WIDTH = 32,
  parameter int BURST_LEN     = 16
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     ic_req_valid,
  input  logic [ADDRESS_WIDTH-1:0] ic_req_address,
  output logic                     ic_req_ready,
  output logic                     ic_rsp_valid,
  output logic                     ic_rsp_last,
  output logic [DATA_WIDTH-1:0]    ic_rsp_data,
  input  logic                     dc_req_valid,
  input  logic                     dc_req_write,
  input  logic [ADDRESS_WIDTH-1:0] dc_req_address,
  output logic                     dc_req_ready,
  input  logic [DATA_WIDTH-1:0]    dc_wdata,
  output logic                     dc_wdata_ready,
  output logic                     dc_rsp_valid,
  output logic                     dc_rsp_last,
  output logic [DATA_WIDTH-1:0]    dc_rsp_data,
  output logic                     mem_req_valid,
  output logic                     mem_req_write,
  output logic [ADDRESS_WIDTH-1:0] mem_req_address,
  input  logic                     mem_req_ready,
  output logic [DATA_WIDTH-1:0]    mem_wdata,
  output logic                     mem_wdata_valid,
  output logic                     mem_wdata_last,
  input  logic                     mem_wdata_ready,
  input  logic                     mem_rsp_valid,
  input  logic                     mem_rsp_last,
  input  logic [DATA_WIDTH-1:0]    mem_rsp_data
);

  localparam int OFF_W = line_offset_w(BURST_LEN);
  localparam int CNT_W = (BURST_LEN > 1) ? $clog2(BURST_LEN) : 1;
  localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(BURST_LEN - 1);

  // Handshakes: a transfer happens in a cycle where valid and ready are both
  // high; the valid side holds its payload stable until that cycle.

  arb_state_t               state_q;
  arb_state_t               state_d;
  owner_t                   owner_q;
  logic                     write_q;
  logic [ADDRESS_WIDTH-1:0] addr_q;
  logic [CNT_W-1:0]         beat_cnt_q;

  logic   take;
  logic   grant_valid;
  owner_t grant_owner;
  logic   grant_fire;
  logic   wbeat_fire;
  logic   wbeat_final;

  assign take        = (state_q == IDLE);
  assign grant_fire  = take && grant_valid;
  assign wbeat_fire  = (state_q == WDATA) && mem_wdata_ready;
  assign wbeat_final = wbeat_fire && (beat_cnt_q == LAST_BEAT);

  cache_arb_rr u_arb (
    .clk         (clk),
    .rst         (rst),
    .req_ic      (ic_req_valid),
    .req_dc      (dc_req_valid),
    .take        (take),
    .grant_valid (grant_valid),
    .grant_owner (grant_owner)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:  if (grant_valid) state_d = ISSUE;
      ISSUE: if (mem_req_ready) state_d = write_q ? WDATA : RDATA;
      RDATA: if (mem_rsp_valid && mem_rsp_last) state_d = IDLE;
      WDATA: if (wbeat_final) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // The I-cache never writes, so only a D-cache grant can set write_q.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      owner_q <= DCACHE;
      write_q <= 1'b0;
      addr_q  <= '0;
    end else if (grant_fire) begin
      owner_q <= grant_owner;
      write_q <= (grant_owner == DCACHE) && dc_req_write;
      addr_q  <= (grant_owner == DCACHE) ? dc_req_address : ic_req_address;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      beat_cnt_q <= '0;
    end else if (wbeat_fire) begin
      beat_cnt_q <= (beat_cnt_q == LAST_BEAT) ? '0 : beat_cnt_q + CNT_W'(1);
    end
  end

  always_comb begin
    ic_req_ready    = 1'b0;
    dc_req_ready    = 1'b0;
    ic_rsp_valid    = 1'b0;
    ic_rsp_last     = 1'b0;
    ic_rsp_data     = '0;
    dc_rsp_valid    = 1'b0;
    dc_rsp_last     = 1'b0;
    dc_rsp_data     = '0;
    dc_wdata_ready  = 1'b0;
    mem_req_valid   = 1'b0;
    mem_req_write   = 1'b0;
    mem_req_address = '0;
    mem_wdata       = '0;
    mem_wdata_valid = 1'b0;
    mem_wdata_last  = 1'b0;
    unique case (state_q)
      IDLE: begin
        // Gated by rst so a requester held valid through reset sees no ready.
        if (!rst && grant_valid) begin
          ic_req_ready = (grant_owner == ICACHE);
          dc_req_ready = (grant_owner == DCACHE);
        end
      end
      ISSUE: begin
        mem_req_valid   = 1'b1;
        mem_req_write   = write_q;
        mem_req_address = {addr_q[ADDRESS_WIDTH-1:OFF_W], {OFF_W{1'b0}}};
      end
      RDATA: begin
        if (owner_q == ICACHE) begin
          ic_rsp_valid = mem_rsp_valid;
          ic_rsp_last  = mem_rsp_valid && mem_rsp_last;
          ic_rsp_data  = mem_rsp_data;
        end else begin
          dc_rsp_valid = mem_rsp_valid;
          dc_rsp_last  = mem_rsp_valid && mem_rsp_last;
          dc_rsp_data  = mem_rsp_data;
        end
      end
      WDATA: begin
        mem_wdata       = dc_wdata;
        mem_wdata_valid = 1'b1;
        mem_wdata_last  = (beat_cnt_q == LAST_BEAT);
        dc_wdata_ready  = mem_wdata_ready;
      end
      default: ;
    endcase
  end

  a_req_stable: assert property (@(posedge clk) disable iff (rst)
    (mem_req_valid && !mem_req_ready) |=>
      (mem_req_valid && $stable(mem_req_address) && $stable(mem_req_write)));

  a_rsp_onehot: assert property (@(posedge clk) disable iff (rst)
    !(ic_rsp_valid && dc_rsp_valid));

endmodule

// File: tb/tb_cache_mem_arbiter.sv
// Directed bench for cache_mem_arbiter: contention order, line read with a
// stalled issue, toggled-ready writeback and reset in the middle of a burst.
module tb_cache_mem_arbiter;
  import cache_mem_pkg::*;

  localparam int DW = 32;
  localparam int AW = 32;
  localparam int BL = 16;

  logic          clk;
  logic          rst;
  logic          ic_req_valid;
  logic [AW-1:0] ic_req_address;
  logic          ic_req_ready;
  logic          ic_rsp_valid;
  logic          ic_rsp_last;
  logic [DW-1:0] ic_rsp_data;
  logic          dc_req_valid;
  logic          dc_req_write;
  logic [AW-1:0] dc_req_address;
  logic          dc_req_ready;
  logic [DW-1:0] dc_wdata;
  logic          dc_wdata_ready;
  logic          dc_rsp_valid;
  logic          dc_rsp_last;
  logic [DW-1:0] dc_rsp_data;
  logic          mem_req_valid;
  logic          mem_req_write;
  logic [AW-1:0] mem_req_address;
  logic          mem_req_ready;
  logic [DW-1:0] mem_wdata;
  logic          mem_wdata_valid;
  logic          mem_wdata_last;
  logic          mem_wdata_ready;
  logic          mem_rsp_valid;
  logic          mem_rsp_last;
  logic [DW-1:0] mem_rsp_data;

  cache_mem_arbiter #(
    .DATA_WIDTH    (DW),
    .ADDRESS_WIDTH (AW),
    .BURST_LEN     (BL)
  ) dut (
    .clk             (clk),
    .rst             (rst),
    .ic_req_valid    (ic_req_valid),
    .ic_req_address  (ic_req_address),
    .ic_req_ready    (ic_req_ready),
    .ic_rsp_valid    (ic_rsp_valid),
    .ic_rsp_last     (ic_rsp_last),
    .ic_rsp_data     (ic_rsp_data),
    .dc_req_valid    (dc_req_valid),
    .dc_req_write    (dc_req_write),
    .dc_req_address  (dc_req_address),
    .dc_req_ready    (dc_req_ready),
    .dc_wdata        (dc_wdata),
    .dc_wdata_ready  (dc_wdata_ready),
    .dc_rsp_valid    (dc_rsp_valid),
    .dc_rsp_last     (dc_rsp_last),
    .dc_rsp_data     (dc_rsp_data),
    .mem_req_valid   (mem_req_valid),
    .mem_req_write   (mem_req_write),
    .mem_req_address (mem_req_address),
    .mem_req_ready   (mem_req_ready),
    .mem_wdata       (mem_wdata),
    .mem_wdata_valid (mem_wdata_valid),
    .mem_wdata_last  (mem_wdata_last),
    .mem_wdata_ready (mem_wdata_ready),
    .mem_rsp_valid   (mem_rsp_valid),
    .mem_rsp_last    (mem_rsp_last),
    .mem_rsp_data    (mem_rsp_data)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: time limit reached before summary");
    $fatal(1, "watchdog expired");
  end

  // ---------------- scoreboard ----------------
  int            n_checks = 0;
  int            n_pass   = 0;
  logic [DW-1:0] exp_q[$];

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: observed 0x%0h, expected 0x%0h", tag, obs, exp);
  endtask

  // ---------------- driver tasks ----------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic release_reset();
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    step();
  endtask

  // Entered in an ISSUE cycle; leaves in the cycle after the handshake.
  task automatic issue_phase(input logic [AW-1:0] exp_addr, input logic exp_write, input int stall);
    for (int k = 0; k < stall; k++) begin
      mem_req_ready = 1'b0;
      mem_rsp_valid = 1'b1;
      mem_rsp_data  = 32'hDEAD_BEEF;
      #1;
      check("stall_req_valid", mem_req_valid, 1'b1);
      check("stall_req_addr", mem_req_address, exp_addr);
      check("stall_req_write", mem_req_write, exp_write);
      check("stall_ic_rsp_valid", ic_rsp_valid, 1'b0);
      check("stall_dc_rsp_valid", dc_rsp_valid, 1'b0);
      step();
    end
    mem_rsp_valid = 1'b0;
    mem_req_ready = 1'b1;
    #1;
    check("issue_req_valid", mem_req_valid, 1'b1);
    check("issue_req_addr", mem_req_address, exp_addr);
    check("issue_req_write", mem_req_write, exp_write);
    step();
    mem_req_ready = 1'b0;
  endtask

  // Entered in the first RDATA cycle; last_idx < 0 means no last beat.
  task automatic run_read(input owner_t own, input int n_beats, input int last_idx,
                          input logic [DW-1:0] base);
    logic [DW-1:0] exp_d;
    for (int i = 0; i < n_beats; i++) begin
      mem_rsp_valid = 1'b1;
      mem_rsp_last  = (i == last_idx);
      mem_rsp_data  = base + DW'(i);
      exp_q.push_back(base + DW'(i));
      #1;
      exp_d = exp_q.pop_front();
      if (own == ICACHE) begin
        check("ic_rsp_valid", ic_rsp_valid, 1'b1);
        check("ic_rsp_last", ic_rsp_last, (i == last_idx));
        check("ic_rsp_data", ic_rsp_data, exp_d);
        check("dc_rsp_quiet", dc_rsp_valid, 1'b0);
        check("dc_req_ready_busy", dc_req_ready, 1'b0);
      end else begin
        check("dc_rsp_valid", dc_rsp_valid, 1'b1);
        check("dc_rsp_last", dc_rsp_last, (i == last_idx));
        check("dc_rsp_data", dc_rsp_data, exp_d);
        check("ic_rsp_quiet", ic_rsp_valid, 1'b0);
        check("ic_req_ready_busy", ic_req_ready, 1'b0);
      end
      if (i < n_beats - 1 || last_idx >= 0) step();
    end
    if (last_idx >= 0) begin
      mem_rsp_valid = 1'b0;
      mem_rsp_last  = 1'b0;
    end
  endtask

  // ---------------- stimulus ----------------
  owner_t        exp_win[3];
  logic [AW-1:0] win_addr;
  int            beats;
  logic          rdy;

  initial begin
`ifdef CACHE_ARB_DCACHE_PRIORITY_EN
    exp_win[0] = DCACHE; exp_win[1] = DCACHE; exp_win[2] = DCACHE;
`else
    exp_win[0] = ICACHE; exp_win[1] = DCACHE; exp_win[2] = ICACHE;
`endif
    rst             = 1'b1;
    ic_req_valid    = 1'b1;
    ic_req_address  = 32'h0000_1234;
    dc_req_valid    = 1'b1;
    dc_req_write    = 1'b1;
    dc_req_address  = 32'h0000_5678;
    dc_wdata        = 32'h1111_2222;
    mem_req_ready   = 1'b1;
    mem_wdata_ready = 1'b1;
    mem_rsp_valid   = 1'b1;
    mem_rsp_last    = 1'b1;
    mem_rsp_data    = 32'hCAFE_F00D;
    #3;
    check("rst_ic_req_ready", ic_req_ready, 1'b0);
    check("rst_dc_req_ready", dc_req_ready, 1'b0);
    check("rst_mem_req_valid", mem_req_valid, 1'b0);
    check("rst_mem_req_addr", mem_req_address, 32'h0);
    check("rst_mem_wdata_valid", mem_wdata_valid, 1'b0);
    check("rst_ic_rsp_valid", ic_rsp_valid, 1'b0);
    check("rst_dc_rsp_data", dc_rsp_data, 32'h0);
    check("rst_dc_wdata_ready", dc_wdata_ready, 1'b0);
    ic_req_valid    = 1'b0;
    dc_req_valid    = 1'b0;
    dc_req_write    = 1'b0;
    mem_req_ready   = 1'b0;
    mem_wdata_ready = 1'b0;
    mem_rsp_valid   = 1'b0;
    mem_rsp_last    = 1'b0;
    release_reset();
    check("post_rst_req_valid", mem_req_valid, 1'b0);

    // Three contention rounds, both requesters kept valid throughout.
    ic_req_valid   = 1'b1;
    dc_req_valid   = 1'b1;
    ic_req_address = 32'h0000_2014;
    dc_req_address = 32'h0001_0028;
    for (int r = 0; r < 3; r++) begin
      #1;
      check("tie_ic_req_ready", ic_req_ready, exp_win[r] == ICACHE);
      check("tie_dc_req_ready", dc_req_ready, exp_win[r] == DCACHE);
      win_addr = (exp_win[r] == ICACHE) ? ic_req_address : dc_req_address;
      step();
      if (exp_win[r] == ICACHE) ic_req_address = ic_req_address + 32'h100;
      else dc_req_address = dc_req_address + 32'h100;
      #1;
      check("issue_no_ic_ready", ic_req_ready, 1'b0);
      check("issue_no_dc_ready", dc_req_ready, 1'b0);
      issue_phase(win_addr & ~32'h3F, 1'b0, 0);
      run_read(exp_win[r], 2, 1, 32'h0000_A000 + DW'(r * 16));
    end
    ic_req_valid = 1'b0;
    dc_req_valid = 1'b0;
    step();

    // I-cache line read at 0x1234 with the memory request stalled 5 cycles.
    ic_req_valid   = 1'b1;
    ic_req_address = 32'h0000_1234;
    #1;
    check("ic_only_ready", ic_req_ready, 1'b1);
    check("ic_only_dc_ready", dc_req_ready, 1'b0);
    step();
    ic_req_valid = 1'b0;
    issue_phase(32'h0000_1200, 1'b0, 5);
    run_read(ICACHE, BL, BL - 1, 32'h0);
    #1;
    check("after_read_idle", mem_req_valid, 1'b0);
    check("after_read_rsp", ic_rsp_valid, 1'b0);

    // D-cache writeback with mem_wdata_ready toggling 1,0,1,...
    dc_req_valid   = 1'b1;
    dc_req_write   = 1'b1;
    dc_req_address = 32'h0000_807C;
    #1;
    check("wb_dc_ready", dc_req_ready, 1'b1);
    check("wb_ic_ready", ic_req_ready, 1'b0);
    step();
    dc_req_valid = 1'b0;
    dc_req_write = 1'b0;
    issue_phase(32'h0000_8040, 1'b1, 0);
    beats = 0;
    for (int cyc = 0; cyc < 64 && beats < BL; cyc++) begin
      rdy             = (cyc % 2 == 0);
      mem_wdata_ready = rdy;
      dc_wdata        = 32'hD000_0000 + DW'(beats);
      #1;
      check("wb_wdata_valid", mem_wdata_valid, 1'b1);
      check("wb_wdata", mem_wdata, 32'hD000_0000 + DW'(beats));
      check("wb_wdata_last", mem_wdata_last, beats == BL - 1);
      check("wb_wdata_ready", dc_wdata_ready, rdy);
      if (rdy) beats++;
      step();
    end
    mem_wdata_ready = 1'b0;
    check("wb_beat_count", beats, BL);
    #1;
    check("wb_done_valid", mem_wdata_valid, 1'b0);
    check("wb_done_req", mem_req_valid, 1'b0);

    // Reset asserted on beat 7 of an I-cache burst.
    ic_req_valid   = 1'b1;
    ic_req_address = 32'h0000_4444;
    #1;
    check("mid_ic_ready", ic_req_ready, 1'b1);
    step();
    ic_req_valid = 1'b0;
    issue_phase(32'h0000_4440, 1'b0, 0);
    run_read(ICACHE, 7, -1, 32'h0000_0100);
    step();
    mem_rsp_valid = 1'b1;
    mem_rsp_last  = 1'b0;
    mem_rsp_data  = 32'h0000_0107;
    #1;
    check("beat7_pre_rst", ic_rsp_valid, 1'b1);
    rst = 1'b1;
    #1;
    check("mid_rst_ic_rsp_valid", ic_rsp_valid, 1'b0);
    check("mid_rst_ic_rsp_data", ic_rsp_data, 32'h0);
    check("mid_rst_dc_rsp_valid", dc_rsp_valid, 1'b0);
    check("mid_rst_req_valid", mem_req_valid, 1'b0);
    mem_rsp_valid = 1'b0;
    release_reset();
    ic_req_valid   = 1'b1;
    ic_req_address = 32'h0000_5000;
    #1;
    check("post_abort_ready", ic_req_ready, 1'b1);
    step();
    ic_req_valid = 1'b0;
    issue_phase(32'h0000_5000, 1'b0, 0);
    run_read(ICACHE, BL, BL - 1, 32'h0000_0500);
    #1;
    check("post_abort_idle", mem_req_valid, 1'b0);
    check("scoreboard_empty", exp_q.size(), 0);

    // ---------------- report ----------------
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/cache_mem_arbiter.md
Name: cache_mem_arbiter

Overview:
Shares the single external memory burst port between the instruction-cache refill path and the data-cache refill/writeback path of the MIPS core. Accepts one line request at a time and forwards it to memory. Holds the grant until the burst completes, then routes the returned beats to the owning cache. Arbitration is round-robin, so neither cache starves during simultaneous misses.

Parameters:
DATA_WIDTH, 32, width of one memory beat
ADDRESS_WIDTH, 32, byte address width
BURST_LEN, 16, beats per cache line (power of two)

Ports:
clk  in  1  clock
rst  in  1  reset
ic_req_valid  in  1  I-cache requests a line read
ic_req_address  in  ADDRESS_WIDTH  I-cache miss address
ic_req_ready  out  1  I-cache request accepted this cycle
ic_rsp_valid  out  1  read beat for I-cache
ic_rsp_last  out  1  final beat for I-cache
ic_rsp_data  out  DATA_WIDTH  beat data
dc_req_valid  in  1  D-cache request
dc_req_write  in  1  1 = line writeback, 0 = line read
dc_req_address  in  ADDRESS_WIDTH  D-cache line address
dc_req_ready  out  1  D-cache request accepted this cycle
dc_wdata  in  DATA_WIDTH  writeback beat
dc_wdata_ready  out  1  writeback beat consumed this cycle
dc_rsp_valid  out  1  read beat for D-cache
dc_rsp_last  out  1  final beat for D-cache
dc_rsp_data  out  DATA_WIDTH  beat data
mem_req_valid  out  1  request to memory
mem_req_write  out  1  request is a write
mem_req_address  out  ADDRESS_WIDTH  line-aligned address
mem_req_ready  in  1  memory accepts request
mem_wdata  out  DATA_WIDTH  write beat
mem_wdata_valid  out  1  write beat valid
mem_wdata_last  out  1  final write beat
mem_wdata_ready  in  1  memory takes write beat
mem_rsp_valid  in  1  read beat valid
mem_rsp_last  in  1  final read beat
mem_rsp_data  in  DATA_WIDTH  read beat

Behaviour:
- Clock and reset: reset rst, asynchronous, active-high; clock clk.
- On reset, every output is 0, the state is IDLE, the beat counter is 0 and last_grant = DCACHE, so the I-cache wins the first tie.
- States:
  - IDLE: sample requesters, pick a winner, latch owner, write flag and address, go to ISSUE in the next cycle. No request means stay in IDLE.
  - ISSUE: drive mem_req_valid/write/address and hold them stable until mem_req_ready. On the handshake, go to RDATA or WDATA.
  - RDATA: forward mem_rsp_valid/last/data only to the owner's rsp port (combinational, 0-cycle latency). The other cache's rsp_valid stays 0. Return to IDLE on mem_rsp_valid && mem_rsp_last.
  - WDATA: mem_wdata = dc_wdata, mem_wdata_valid = 1, dc_wdata_ready = mem_wdata_ready. The counter increments per accepted beat. mem_wdata_last = 1 when counter == BURST_LEN-1. On the last accepted beat, clear the counter and return to IDLE.
- ic_req_ready / dc_req_ready pulse for one cycle in the IDLE cycle the grant is taken. A requester holds valid and address until it sees ready.
- Arbitration: if only one requester is valid, it wins. If both are valid, the side that is not last_grant wins, and last_grant updates on every grant.
- mem_req_address = latched address with the low log2(BURST_LEN)+2 bits cleared.
- The I-cache never writes; ic requests always enter RDATA.
- A new grant takes at least one IDLE cycle after each burst (no back-to-back overlap).
- mem_rsp_valid outside RDATA is ignored.
- If mem_rsp_last arrives early (before BURST_LEN beats), the burst still terminates on last.
- Reset mid-burst aborts immediately to the reset state; requesters must re-request.

Optional Feature:
- Macro: CACHE_ARB_DCACHE_PRIORITY_EN.
- Defined: fixed priority, where the D-cache always wins a tie and last_grant is unused.
- Undefined: round-robin as described under Behaviour.

Decomposition:
- Shared package cache_mem_pkg holds:
  - state encoding (IDLE, ISSUE, RDATA, WDATA)
  - owner encoding (ICACHE = 0, DCACHE = 1)
  - the BURST_LEN-derived offset-width constant, for reuse by both caches.
- One natural sub-module: cache_arb_rr, a 2-input round-robin picker with last_grant register and macro-selected fixed-priority mode.

Test Plan:
- ic read only at 0x0000_1234: mem_req_address = 0x0000_1200 after the handshake; 16 beats 0..15 appear on ic_rsp, ic_rsp_last on beat 15, dc_rsp_valid stays 0.
- ic and dc read both valid in the same cycle after reset: ic granted first; dc granted only after ic's last beat plus one IDLE cycle. Repeat with both valid again: dc wins.
- dc writeback of 16 beats with mem_wdata_ready toggling 1,0,1,...: exactly 16 beats transferred, mem_wdata_last only on the 16th accepted beat, then IDLE.
- mem_req_ready held 0 for 5 cycles in ISSUE: request signals stay stable, no rsp forwarding, and the burst proceeds after ready.
- rst asserted at beat 7 of an ic burst: all outputs go to 0 immediately; a fresh ic request afterwards is granted normally.
- With CACHE_ARB_DCACHE_PRIORITY_EN defined, ic and dc contend three times: dc wins every time.
